// File: rtl/counter_pkg.sv
// Shared constants and helpers for the counter_nb block: mode encodings and
// binary-to-Gray conversion.
package counter_pkg;
  localparam int MODE_SAT  = 0;
  localparam int MODE_WRAP = 1;
  localparam int MAX_W     = 16;

  // Callers zero-extend to MAX_W bits and truncate the result back to their width.
  function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction
endpackage

// File: rtl/adder_nb.sv
// WIDTH-bit ripple-carry adder, one full_adder cell per bit.
module adder_nb #(
  parameter int WIDTH = 6
) (
  output logic [WIDTH-1:0] Sum,
  output logic             C_out,
  input  logic [WIDTH-1:0] Input1,
  input  logic [WIDTH-1:0] Input2,
  input  logic             C_in
);
  logic [WIDTH:0] c;
  assign c[0] = C_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .A    (Input1[i]),
      .B    (Input2[i]),
      .C_in (c[i]),
      .Sum  (Sum[i]),
      .C_out(c[i+1])
    );
  end

  assign C_out = c[WIDTH];
endmodule

// File: rtl/full_adder.sv
// 1-bit full adder cell; the ripple adder is built from these.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic C_in,
  output logic Sum,
  output logic C_out
);
  assign Sum   = A ^ B ^ C_in;
  assign C_out = (A & B) | (C_in & (A ^ B));
endmodule

// File: rtl/counter_nb.sv
// Modulo-DEPTH up/down counter with load, clear, wrap/saturate modes,
// registered Gray output and a one-cycle wrap/saturation pulse.
module counter_nb
  import counter_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int DEPTH = 64,
  parameter int WRAP  = MODE_WRAP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             En,
  input  logic             Clr,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  input  logic             Inc,
  input  logic             Dec,
  output logic [WIDTH-1:0] Count,
  output logic [WIDTH-1:0] Gray,
  output logic             Zero,
  output logic             Max,
  output logic             Wrap_p
);
  if (WIDTH < 2 || WIDTH > MAX_W || DEPTH < 2 || DEPTH > (1 << WIDTH) ||
      (WRAP != MODE_WRAP && WRAP != MODE_SAT)) begin : g_bad_params
    $fatal(1, "counter_nb: illegal WIDTH/DEPTH/WRAP combination");
  end

  localparam logic [WIDTH-1:0] TOP = WIDTH'(DEPTH - 1);

  logic [WIDTH-1:0] cnt_q, cnt_d, gray_q, gray_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] add_b, add_sum;
  logic             add_ci, add_co_unused, dec_only;

  // Decrement adds all-ones with no carry-in; increment adds zero with carry-in.
  assign dec_only = Dec & ~Inc;
  assign add_b    = dec_only ? '1 : '0;
  assign add_ci   = ~dec_only;

  adder_nb #(.WIDTH(WIDTH)) u_add (
    .Sum   (add_sum),
    .C_out (add_co_unused),
    .Input1(cnt_q),
    .Input2(add_b),
    .C_in  (add_ci)
  );

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      if (Load) begin
        cnt_d = (Din > TOP) ? TOP : Din;
      end else if (Inc && Dec) begin
        cnt_d = cnt_q;
      end else if (Inc) begin
        if (cnt_q == TOP) begin
          wrap_d = 1'b1;
          if (WRAP == MODE_WRAP) cnt_d = '0;
        end else begin
          cnt_d = add_sum;
        end
      end else if (Dec) begin
        if (cnt_q == '0) begin
          wrap_d = 1'b1;
          if (WRAP == MODE_WRAP) cnt_d = TOP;
        end else begin
          cnt_d = add_sum;
        end
      end
    end
    gray_d = WIDTH'(bin2gray(MAX_W'(cnt_d)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      gray_q <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gray_q <= gray_d;
      wrap_q <= wrap_d;
    end
  end

  assign Count  = cnt_q;
  assign Gray   = gray_q;
  assign Wrap_p = wrap_q;
  assign Zero   = (cnt_q == '0);
  assign Max    = (cnt_q == TOP);
endmodule

// File: tb/tb_counter_nb.sv
// Directed bench for counter_nb: three configurations share one stimulus bus.
module tb_counter_nb;
  logic clk = 1'b0, rst_n = 1'b0;
  logic en = 0, clr = 0, load = 0, inc = 0, dec = 0;
  logic [5:0] din = '0;

  logic [5:0] c6, g6;
  logic       z6, m6, w6;
  logic [3:0] c10, g10, c16, g16;
  logic       z10, m10, w10, z16, m16, w16;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  counter_nb #(.WIDTH(6), .DEPTH(64), .WRAP(1)) u6 (
    .clk(clk), .rst_n(rst_n), .En(en), .Clr(clr), .Load(load), .Din(din),
    .Inc(inc), .Dec(dec), .Count(c6), .Gray(g6), .Zero(z6), .Max(m6), .Wrap_p(w6));
  counter_nb #(.WIDTH(4), .DEPTH(10), .WRAP(0)) u10 (
    .clk(clk), .rst_n(rst_n), .En(en), .Clr(clr), .Load(load), .Din(din[3:0]),
    .Inc(inc), .Dec(dec), .Count(c10), .Gray(g10), .Zero(z10), .Max(m10), .Wrap_p(w10));
  counter_nb #(.WIDTH(4), .DEPTH(16), .WRAP(1)) u16 (
    .clk(clk), .rst_n(rst_n), .En(en), .Clr(clr), .Load(load), .Din(din[3:0]),
    .Inc(inc), .Dec(dec), .Count(c16), .Gray(g16), .Zero(z16), .Max(m16), .Wrap_p(w16));

  typedef struct {
    logic       en, clr, load, inc, dec;
    logic [3:0] din;
    logic [3:0] cnt;
    logic       wp, zero, max;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic e, c, l, i, d, input logic [5:0] v);
    en = e; clr = c; load = l; inc = i; dec = d; din = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  vec_t vt[21];
  logic [3:0] gexp[16];
  logic [3:0] prev_g;

  initial begin
    // DEPTH=10, saturating configuration
    vt[0]  = '{1,0,0,0,1, 4'd0,  4'd0, 1,1,0};
    vt[1]  = '{1,0,0,0,0, 4'd0,  4'd0, 0,1,0};
    vt[2]  = '{1,0,1,0,0, 4'd12, 4'd9, 0,0,1};
    vt[3]  = '{1,0,0,1,0, 4'd0,  4'd9, 1,0,1};
    vt[4]  = '{1,0,0,1,0, 4'd0,  4'd9, 1,0,1};
    vt[5]  = '{0,0,0,1,0, 4'd0,  4'd9, 0,0,1};
    vt[6]  = '{1,0,0,0,1, 4'd0,  4'd8, 0,0,0};
    vt[7]  = '{1,0,1,0,0, 4'd5,  4'd5, 0,0,0};
    vt[8]  = '{1,0,0,1,1, 4'd0,  4'd5, 0,0,0};
    vt[9]  = '{0,0,0,1,0, 4'd0,  4'd5, 0,0,0};
    vt[10] = '{0,0,0,0,1, 4'd0,  4'd5, 0,0,0};
    vt[11] = '{0,1,0,0,0, 4'd0,  4'd0, 0,1,0};
    vt[12] = '{1,0,1,0,0, 4'd9,  4'd9, 0,0,1};
    vt[13] = '{1,1,1,1,0, 4'd3,  4'd0, 0,1,0};
    vt[14] = '{1,0,0,1,0, 4'd0,  4'd1, 0,0,0};
    vt[15] = '{1,0,0,1,0, 4'd0,  4'd2, 0,0,0};
    vt[16] = '{0,0,1,0,0, 4'd7,  4'd2, 0,0,0};
    vt[17] = '{1,0,1,0,0, 4'd15, 4'd9, 0,0,1};
    vt[18] = '{1,0,0,0,1, 4'd0,  4'd8, 0,0,0};
    vt[19] = '{1,0,1,0,0, 4'd0,  4'd0, 0,1,0};
    vt[20] = '{1,0,0,1,1, 4'd0,  4'd0, 0,1,0};
    gexp = '{4'h0,4'h1,4'h3,4'h2,4'h6,4'h7,4'h5,4'h4,
             4'hC,4'hD,4'hF,4'hE,4'hA,4'hB,4'h9,4'h8};

    #2;
    chk("rst c6", c6, 0);   chk("rst g6", g6, 0);   chk("rst z6", z6, 1);
    chk("rst m6", m6, 0);   chk("rst w6", w6, 0);
    chk("rst c10", c10, 0); chk("rst g10", g10, 0); chk("rst z10", z10, 1);
    chk("rst m10", m10, 0); chk("rst w10", w10, 0);
    chk("rst c16", c16, 0); chk("rst z16", z16, 1); chk("rst m16", m16, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 21; k++) begin
      drive(vt[k].en, vt[k].clr, vt[k].load, vt[k].inc, vt[k].dec, {2'b00, vt[k].din});
      tick();
      chk($sformatf("v%0d count", k), c10, vt[k].cnt);
      chk($sformatf("v%0d wrap_p", k), w10, vt[k].wp);
      chk($sformatf("v%0d zero", k), z10, vt[k].zero);
      chk($sformatf("v%0d max", k), m10, vt[k].max);
      chk($sformatf("v%0d gray", k), g10, vt[k].cnt ^ (vt[k].cnt >> 1));
    end

    // 6-bit wrap at 64
    drive(1,1,0,0,0, 6'd0);  tick();
    drive(1,0,1,0,0, 6'd62); tick();
    chk("w6 load62", c6, 62);
    drive(1,0,0,1,0, 6'd0);  tick();
    chk("w6 inc1 cnt", c6, 63); chk("w6 inc1 wp", w6, 0); chk("w6 inc1 max", m6, 1);
    chk("w6 inc1 gray", g6, 63 ^ 31);
    tick();
    chk("w6 inc2 cnt", c6, 0); chk("w6 inc2 wp", w6, 1); chk("w6 inc2 zero", z6, 1);
    chk("w6 inc2 gray", g6, 0);
    tick();
    chk("w6 inc3 cnt", c6, 1); chk("w6 inc3 wp", w6, 0); chk("w6 inc3 gray", g6, 1);

    // 4-bit Gray walk, then wrap both directions
    drive(1,1,0,0,0, 6'd0); tick();
    chk("gray start", g16, 0);
    prev_g = g16;
    drive(1,0,0,1,0, 6'd0);
    for (int k = 1; k < 16; k++) begin
      tick();
      chk($sformatf("gray cnt%0d", k), c16, k);
      chk($sformatf("gray val%0d", k), g16, gexp[k]);
      chk($sformatf("gray ham%0d", k), $countones(prev_g ^ g16), 1);
      prev_g = g16;
    end
    tick();
    chk("w16 wrap cnt", c16, 0); chk("w16 wrap wp", w16, 1);
    drive(1,0,0,0,1, 6'd0); tick();
    chk("w16 under cnt", c16, 15); chk("w16 under wp", w16, 1); chk("w16 under max", m16, 1);
    tick();
    chk("w16 dec cnt", c16, 14); chk("w16 dec wp", w16, 0);

    // Asynchronous reset between edges
    drive(1,0,1,0,0, 6'd7); tick();
    chk("pre-rst cnt", c16, 7);
    drive(1,0,0,1,0, 6'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("async cnt", c16, 0); chk("async gray", g16, 0);
    chk("async zero", z16, 1); chk("async max", m16, 0); chk("async wp", w16, 0);
    @(negedge clk);
    chk("held rst cnt", c16, 0);
    rst_n = 1'b1;
    tick();
    chk("post-rst cnt", c16, 1); chk("post-rst gray", g16, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
